multi_lane_instr_queue: RTL

- Parametrised successor to the fixed two-FIFO instruction path between instr_receiver and iseq_dispatcher.
- Packs a serial stream of instructions into N_LANES-wide issue groups, one instruction per DFI phase.
- Holds groups until a whole instruction sequence has been committed, then presents them to the dispatcher one group per pop.
- Adds sequence commit, NOP padding of partial groups, occupancy reporting and sticky error flags.

---
 rtl/multi_lane_instr_queue_if.sv | 35 +++
 rtl/multi_lane_instr_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multi_lane_instr_queue_if.sv
// Handshake bundle between the instruction receiver (master side drives
// writes and pops) and the multi-lane instruction queue (slave side).
interface multi_lane_instr_queue_if #(
    parameter int N_LANES     = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 64
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                           wr_en;
    logic [INSTR_WIDTH-1:0]         wr_instr;
    logic                           wr_last;
    logic                           wr_ready;
    logic                           rd_en;
    logic                           rd_valid;
    logic [N_LANES*INSTR_WIDTH-1:0] rd_group;
    logic                           rd_last;
    logic [LVL_W-1:0]               level;
    logic [LVL_W-1:0]               seq_count;
    logic                           full;
    logic                           err_overflow;
    logic                           err_underflow;

    modport master (
        output wr_en, wr_instr, wr_last, rd_en,
        input  wr_ready, rd_valid, rd_group, rd_last, level, seq_count,
               full, err_overflow, err_underflow
    );

    modport slave (
        input  wr_en, wr_instr, wr_last, rd_en,
        output wr_ready, rd_valid, rd_group, rd_last, level, seq_count,
               full, err_overflow, err_underflow
    );
endinterface

// File: rtl/multi_lane_instr_queue.sv
// Multi-lane instruction queue: packs a serial instruction stream into
// N_LANES-wide issue groups, holds them until the whole sequence is
// committed (wr_last) and presents committed groups first-word-fall-through.
module multi_lane_instr_queue #(
    parameter int                     N_LANES     = 2,
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     DEPTH       = 64,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    multi_lane_instr_queue_if.slave       bus
);
    localparam int GW     = N_LANES * INSTR_WIDTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
    localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [GW-1:0]     NOP_GROUP = {N_LANES{NOP_INSTR}};

    // Staging of a partially filled group
    logic [INSTR_WIDTH-1:0] stage_r [N_LANES];
    logic [LANE_W-1:0]      lane_ptr_r;

    // Group storage: {last flag, group}
    logic [GW:0]            mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;

    logic [LVL_W-1:0]       level_r;
    logic [LVL_W-1:0]       seq_count_r;
    logic [LVL_W-1:0]       committed_r;
    logic [LVL_W-1:0]       uncommitted_r;

    logic                   wr_ready_r;
    logic                   rd_valid_r;
    logic                   rd_last_r;
    logic [GW-1:0]          rd_group_r;
    logic                   full_r;
    logic                   err_ovf_r;
    logic                   err_unf_r;

    logic                   accept_s;
    logic                   push_s;
    logic                   commit_s;
    logic                   pop_s;
    logic [GW-1:0]          push_group_s;
    logic [PTR_W-1:0]       rd_ptr_next_s;
    logic [LVL_W-1:0]       level_next_s;
    logic [LVL_W-1:0]       added_s;
    logic [LVL_W-1:0]       committed_next_s;
    logic [GW:0]            head_entry_s;

    // Handshake decode, group assembly and next-state counter arithmetic
    always_comb begin
        accept_s     = bus.wr_en && wr_ready_r;
        push_s       = accept_s && (bus.wr_last || (lane_ptr_r == LAST_LANE));
        commit_s     = push_s && bus.wr_last;
        pop_s        = bus.rd_en && rd_valid_r;
        push_group_s = NOP_GROUP;
        for (int i = 0; i < N_LANES; i++) begin
            if (i < int'(lane_ptr_r)) begin
                push_group_s[i*INSTR_WIDTH +: INSTR_WIDTH] = stage_r[i];
            end else if (i == int'(lane_ptr_r)) begin
                push_group_s[i*INSTR_WIDTH +: INSTR_WIDTH] = bus.wr_instr;
            end else begin
                push_group_s[i*INSTR_WIDTH +: INSTR_WIDTH] = NOP_INSTR;
            end
        end
        rd_ptr_next_s    = rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
        level_next_s     = level_r + {{(LVL_W-1){1'b0}}, push_s}
                                   - {{(LVL_W-1){1'b0}}, pop_s};
        if (commit_s) begin
            added_s = uncommitted_r + LVL_W'(1);
        end else begin
            added_s = '0;
        end
        committed_next_s = committed_r + added_s - {{(LVL_W-1){1'b0}}, pop_s};
        // A group pushed into the slot that becomes the head is forwarded directly
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_entry_s = {commit_s, push_group_s};
        end else begin
            head_entry_s = mem_r[rd_ptr_next_s];
        end
    end

    // Group storage write port (contents are qualified by the counters, no reset needed)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {commit_s, push_group_s};
        end
    end

    // Staging, pointers, counters, registered outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                stage_r[i] <= NOP_INSTR;
            end
            lane_ptr_r    <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            level_r       <= '0;
            seq_count_r   <= '0;
            committed_r   <= '0;
            uncommitted_r <= '0;
            wr_ready_r    <= 1'b1;
            rd_valid_r    <= 1'b0;
            rd_last_r     <= 1'b0;
            rd_group_r    <= NOP_GROUP;
            full_r        <= 1'b0;
            err_ovf_r     <= 1'b0;
            err_unf_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                if (push_s) begin
                    for (int i = 0; i < N_LANES; i++) begin
                        stage_r[i] <= NOP_INSTR;
                    end
                    lane_ptr_r <= '0;
                end else begin
                    stage_r[lane_ptr_r] <= bus.wr_instr;
                    lane_ptr_r          <= lane_ptr_r + LANE_W'(1);
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (commit_s) begin
                uncommitted_r <= '0;
            end else if (push_s) begin
                uncommitted_r <= uncommitted_r + LVL_W'(1);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            committed_r <= committed_next_s;
            seq_count_r <= seq_count_r + {{(LVL_W-1){1'b0}}, commit_s}
                                       - {{(LVL_W-1){1'b0}}, (pop_s && rd_last_r)};
            wr_ready_r  <= (level_next_s < DEPTH_L);
            full_r      <= (level_next_s == DEPTH_L);
            rd_valid_r  <= (committed_next_s != '0);
            // Only committed groups are ever shown; otherwise the bus idles at NOP
            if (committed_next_s != '0) begin
                rd_group_r <= head_entry_s[GW-1:0];
                rd_last_r  <= head_entry_s[GW];
            end else begin
                rd_group_r <= NOP_GROUP;
                rd_last_r  <= 1'b0;
            end
            if (bus.wr_en && !wr_ready_r) begin
                err_ovf_r <= 1'b1;
            end
            if (bus.rd_en && !rd_valid_r) begin
                err_unf_r <= 1'b1;
            end
        end
    end

    assign bus.wr_ready      = wr_ready_r;
    assign bus.rd_valid      = rd_valid_r;
    assign bus.rd_group      = rd_group_r;
    assign bus.rd_last       = rd_last_r;
    assign bus.level         = level_r;
    assign bus.seq_count     = seq_count_r;
    assign bus.full          = full_r;
    assign bus.err_overflow  = err_ovf_r;
    assign bus.err_underflow = err_unf_r;
endmodule
